pzcorebus_upsizer_write_packer: RTL and testbench

PZCOREBUS_UPSIZER_WRITE_PACKER -- requirements
Module: pzcorebus_upsizer_write_packer

---
 rtl/pzcorebus_upsizer_write_packer.sv | 149 ++++++++++++++
 tb/tb_pzcorebus_upsizer_write_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pzcorebus_upsizer_write_packer.sv
// Write-data packer for a bus upsizer: gathers narrow write beats into one wide word.
//
// Each write burst has one info entry, which gives the start lane and the atomic flag.
// Beats fill the accumulator lane by lane. A beat that lands on the top lane, or that is
// the last beat of its burst, closes the wide word. That word goes to a one-entry output
// register.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_info_*, o_info_ready        per-burst start lane / atomic flag
//   i_mdata_*, o_sdata_accept     narrow beat input
//   o_mdata_*, i_sdata_accept     wide word output
//   o_busy                        a burst is partially consumed
module pzcorebus_upsizer_write_packer #(
  parameter int unsigned SLAVE_DATA_WIDTH = 32,
  parameter int unsigned CONVERSION_RATIO = 4,
  localparam int unsigned LANE_WIDTH =
    (CONVERSION_RATIO > 1) ? $clog2(CONVERSION_RATIO) : 1,
  localparam int unsigned BYTEEN_WIDTH = SLAVE_DATA_WIDTH / 8,
  localparam int unsigned MASTER_DATA_WIDTH = SLAVE_DATA_WIDTH * CONVERSION_RATIO,
  localparam int unsigned MASTER_BYTEEN_WIDTH = BYTEEN_WIDTH * CONVERSION_RATIO
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_info_valid,
  output logic                           o_info_ready,
  input  logic [LANE_WIDTH-1:0]          i_info_lane,
  input  logic                           i_info_atomic,
  input  logic                           i_mdata_valid,
  output logic                           o_sdata_accept,
  input  logic [SLAVE_DATA_WIDTH-1:0]    i_mdata,
  input  logic [BYTEEN_WIDTH-1:0]        i_mdata_byteen,
  input  logic                           i_mdata_last,
  output logic                           o_mdata_valid,
  input  logic                           i_sdata_accept,
  output logic [MASTER_DATA_WIDTH-1:0]   o_mdata,
  output logic [MASTER_BYTEEN_WIDTH-1:0] o_mdata_byteen,
  output logic                           o_mdata_last,
  output logic                           o_busy
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  typedef logic [CONVERSION_RATIO-1:0][SLAVE_DATA_WIDTH-1:0] wide_data_t;
  typedef logic [CONVERSION_RATIO-1:0][BYTEEN_WIDTH-1:0]     wide_be_t;

  state_e                state_q, state_d;
  logic [LANE_WIDTH-1:0] lane_q, lane_d;
  wide_data_t            acc_data_q, acc_data_d;
  wide_be_t              acc_be_q, acc_be_d;
  logic                  out_valid_q, out_valid_d;
  wide_data_t            out_data_q, out_data_d;
  wide_be_t              out_be_q, out_be_d;
  logic                  out_last_q, out_last_d;

  logic [LANE_WIDTH-1:0] cur_lane;
  logic                  emit;
  logic                  accept;
  logic                  beat_take;
  wide_data_t            merged_data;
  wide_be_t              merged_be;

  always_comb begin
    cur_lane = '0;
    if (CONVERSION_RATIO > 1) begin
      if (state_q == StIdle) begin
        cur_lane = i_info_atomic ? '0 : i_info_lane;
      end else begin
        cur_lane = lane_q;
      end
    end
    emit = (cur_lane == LANE_WIDTH'(CONVERSION_RATIO - 1)) || i_mdata_last;
    // The accept does not look at i_mdata_valid. An emitting beat needs room in the
    // output register, either because it is empty or because it drains this cycle.
    accept = ((state_q == StActive) || i_info_valid) &&
             (!emit || !out_valid_q || i_sdata_accept);
    beat_take = i_mdata_valid && accept;

    merged_data = acc_data_q;
    merged_be   = acc_be_q;
    for (int unsigned i = 0; i < CONVERSION_RATIO; i++) begin
      if (cur_lane == LANE_WIDTH'(i)) begin
        merged_data[i] = i_mdata;
        merged_be[i]   = i_mdata_byteen;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_data_d  = acc_data_q;
    acc_be_d    = acc_be_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    out_last_d  = out_last_q;

    if (i_sdata_accept) begin
      out_valid_d = 1'b0;
    end

    if (beat_take) begin
      state_d = i_mdata_last ? StIdle : StActive;
      lane_d  = (CONVERSION_RATIO > 1) ? cur_lane + 1'b1 : '0;
      if (emit) begin
        out_valid_d = 1'b1;
        out_data_d  = merged_data;
        out_be_d    = merged_be;
        out_last_d  = i_mdata_last;
        acc_be_d    = '0;
      end else begin
        acc_data_d = merged_data;
        acc_be_d   = merged_be;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      lane_q      <= '0;
      acc_data_q  <= '0;
      acc_be_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      acc_data_q  <= acc_data_d;
      acc_be_q    <= acc_be_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
      out_last_q  <= out_last_d;
    end
  end

  assign o_info_ready   = (state_q == StIdle) && beat_take;
  assign o_sdata_accept = accept;
  assign o_mdata_valid  = out_valid_q;
  assign o_mdata        = out_data_q;
  assign o_mdata_byteen = out_be_q;
  assign o_mdata_last   = out_last_q;
  assign o_busy         = (state_q == StActive);

endmodule

// File: tb/tb_pzcorebus_upsizer_write_packer.sv
// Directed bench for the write packer at 32-bit beats and ratio 4.
module tb_pzcorebus_upsizer_write_packer;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_info_valid;
  logic         o_info_ready;
  logic [1:0]   i_info_lane;
  logic         i_info_atomic;
  logic         i_mdata_valid;
  logic         o_sdata_accept;
  logic [31:0]  i_mdata;
  logic [3:0]   i_mdata_byteen;
  logic         i_mdata_last;
  logic         o_mdata_valid;
  logic         i_sdata_accept;
  logic [127:0] o_mdata;
  logic [15:0]  o_mdata_byteen;
  logic         o_mdata_last;
  logic         o_busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 i_clk = ~i_clk;

  pzcorebus_upsizer_write_packer #(
    .SLAVE_DATA_WIDTH (32),
    .CONVERSION_RATIO (4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_info_valid   (i_info_valid),
    .o_info_ready   (o_info_ready),
    .i_info_lane    (i_info_lane),
    .i_info_atomic  (i_info_atomic),
    .i_mdata_valid  (i_mdata_valid),
    .o_sdata_accept (o_sdata_accept),
    .i_mdata        (i_mdata),
    .i_mdata_byteen (i_mdata_byteen),
    .i_mdata_last   (i_mdata_last),
    .o_mdata_valid  (o_mdata_valid),
    .i_sdata_accept (i_sdata_accept),
    .o_mdata        (o_mdata),
    .o_mdata_byteen (o_mdata_byteen),
    .o_mdata_last   (o_mdata_last),
    .o_busy         (o_busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present one beat (or none when mv=0), then let comb outputs settle.
  task automatic drive(input logic iv, input logic [1:0] ln, input logic at, input logic mv,
                       input logic [31:0] d, input logic [3:0] be, input logic last,
                       input logic sacc);
    i_info_valid   = iv;
    i_info_lane    = ln;
    i_info_atomic  = at;
    i_mdata_valid  = mv;
    i_mdata        = d;
    i_mdata_byteen = be;
    i_mdata_last   = last;
    i_sdata_accept = sacc;
    #1;
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    check("rst_valid", o_mdata_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_last", o_mdata_last, 0);
    check("rst_be", o_mdata_byteen, 0);
    i_rst = 1'b0;
    // A beat without info must not be taken.
    drive(0, 0, 0, 1, 32'hDEAD_0000, 4'hF, 1, 1);
    check("noinfo_accept", o_sdata_accept, 0);
    check("noinfo_ready", o_info_ready, 0);
    tick;
    check("noinfo_valid", o_mdata_valid, 0);

    // Lane 0, four full beats.
    drive(1, 0, 0, 1, 32'hA000_0000, 4'hF, 0, 1);
    check("t1_info_ready", o_info_ready, 1);
    check("t1_accept0", o_sdata_accept, 1);
    tick;
    check("t1_busy", o_busy, 1);
    check("t1_valid0", o_mdata_valid, 0);
    drive(0, 0, 0, 1, 32'hA111_1111, 4'hF, 0, 1);
    check("t1_ready_active", o_info_ready, 0);
    tick;
    drive(0, 0, 0, 1, 32'hA222_2222, 4'hF, 0, 1);
    tick;
    check("t1_valid2", o_mdata_valid, 0);
    drive(0, 0, 0, 1, 32'hA333_3333, 4'hF, 1, 1);
    tick;
    check("t1_valid", o_mdata_valid, 1);
    check("t1_data", o_mdata, 128'hA333_3333_A222_2222_A111_1111_A000_0000);
    check("t1_be", o_mdata_byteen, 16'hFFFF);
    check("t1_last", o_mdata_last, 1);
    check("t1_busy_end", o_busy, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick;
    check("t1_drain", o_mdata_valid, 0);

    // Lane 2 start: two words, lanes 2..3 then 0..1.
    drive(1, 2, 0, 1, 32'hB000_0000, 4'hF, 0, 1);
    tick;
    drive(0, 0, 0, 1, 32'hB111_1111, 4'hF, 0, 1);
    tick;
    check("t2_valid1", o_mdata_valid, 1);
    check("t2_data1", o_mdata[127:64], 64'hB111_1111_B000_0000);
    check("t2_be1", o_mdata_byteen, 16'hFF00);
    check("t2_last1", o_mdata_last, 0);
    drive(0, 0, 0, 1, 32'hB222_2222, 4'hF, 0, 1);
    tick;
    check("t2_mid_valid", o_mdata_valid, 0);
    drive(0, 0, 0, 1, 32'hB333_3333, 4'hF, 1, 1);
    tick;
    check("t2_valid2", o_mdata_valid, 1);
    check("t2_data2", o_mdata[63:0], 64'hB333_3333_B222_2222);
    check("t2_be2", o_mdata_byteen, 16'h00FF);
    check("t2_last2", o_mdata_last, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick;

    // Atomic forces lane 0.
    drive(1, 3, 1, 1, 32'hC000_0000, 4'hF, 1, 1);
    check("t3_ready", o_info_ready, 1);
    tick;
    check("t3_data", o_mdata[31:0], 32'hC000_0000);
    check("t3_be", o_mdata_byteen, 16'h000F);
    check("t3_last", o_mdata_last, 1);
    check("t3_busy", o_busy, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick;

    // Fill the output register, then stall the emitting beat of a lane-0 burst.
    drive(1, 0, 1, 1, 32'hD000_0000, 4'hF, 1, 0);
    tick;
    check("t4_full", o_mdata_valid, 1);
    drive(1, 0, 0, 1, 32'hE000_0000, 4'hF, 0, 0);
    check("t4_acc0", o_sdata_accept, 1);
    tick;
    drive(0, 0, 0, 1, 32'hE111_1111, 4'hF, 0, 0);
    check("t4_acc1", o_sdata_accept, 1);
    tick;
    drive(0, 0, 0, 1, 32'hE222_2222, 4'hF, 0, 0);
    check("t4_acc2", o_sdata_accept, 1);
    tick;
    drive(0, 0, 0, 1, 32'hE333_3333, 4'hF, 1, 0);
    check("t4_stall", o_sdata_accept, 0);
    tick;
    check("t4_hold_be", o_mdata_byteen, 16'h000F);
    check("t4_hold_data", o_mdata[31:0], 32'hD000_0000);
    check("t4_hold_busy", o_busy, 1);
    tick;
    check("t4_hold_valid", o_mdata_valid, 1);
    check("t4_hold_be2", o_mdata_byteen, 16'h000F);
    check("t4_stall2", o_sdata_accept, 0);
    drive(0, 0, 0, 1, 32'hE333_3333, 4'hF, 1, 1);
    check("t4_release", o_sdata_accept, 1);
    tick;
    check("t4_valid", o_mdata_valid, 1);
    check("t4_data", o_mdata, 128'hE333_3333_E222_2222_E111_1111_E000_0000);
    check("t4_be", o_mdata_byteen, 16'hFFFF);
    check("t4_busy_end", o_busy, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick;

    // Reset mid-burst, then restart from lane 1.
    drive(1, 0, 0, 1, 32'hF000_0000, 4'hF, 0, 1);
    tick;
    drive(0, 0, 0, 1, 32'hF111_1111, 4'hF, 0, 1);
    tick;
    check("t5_busy_pre", o_busy, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    check("t5_rst_valid", o_mdata_valid, 0);
    check("t5_rst_busy", o_busy, 0);
    drive(1, 1, 0, 1, 32'h6000_0000, 4'hF, 0, 1);
    check("t5_ready", o_info_ready, 1);
    tick;
    drive(0, 0, 0, 1, 32'h6111_1111, 4'hF, 0, 1);
    tick;
    drive(0, 0, 0, 1, 32'h6222_2222, 4'hF, 1, 1);
    tick;
    check("t5_valid", o_mdata_valid, 1);
    check("t5_be", o_mdata_byteen, 16'hFFF0);
    check("t5_data", o_mdata[127:32], 96'h6222_2222_6111_1111_6000_0000);
    check("t5_last", o_mdata_last, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick;

    // Back-to-back single-beat bursts, one per cycle.
    drive(1, 1, 0, 1, 32'h7000_0001, 4'hF, 1, 1);
    check("t6_ready0", o_info_ready, 1);
    tick;
    check("t6_valid0", o_mdata_valid, 1);
    check("t6_be0", o_mdata_byteen, 16'h00F0);
    check("t6_data0", o_mdata[63:32], 32'h7000_0001);
    drive(1, 2, 0, 1, 32'h7000_0002, 4'hF, 1, 1);
    check("t6_ready1", o_info_ready, 1);
    tick;
    check("t6_valid1", o_mdata_valid, 1);
    check("t6_be1", o_mdata_byteen, 16'h0F00);
    check("t6_data1", o_mdata[95:64], 32'h7000_0002);
    drive(1, 0, 0, 1, 32'h7000_0003, 4'hF, 1, 1);
    check("t6_ready2", o_info_ready, 1);
    tick;
    check("t6_valid2", o_mdata_valid, 1);
    check("t6_be2", o_mdata_byteen, 16'h000F);
    check("t6_data2", o_mdata[31:0], 32'h7000_0003);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick;
    check("t6_drain", o_mdata_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
